anim_frame_seq: RTL and testbench

ANIM_FRAME_SEQ -- requirements
Module: anim_frame_seq

---
 rtl/anim_pkg.sv | 16 +
 rtl/anim_prescaler.sv | 53 +++++
 rtl/anim_frame_seq.sv | 149 ++++++++++++++
 tb/tb_anim_frame_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// anim_pkg -- shared definitions for the animation frame sequencer.
//   seq_state_e : bounce direction state (UP counts toward LAST, DOWN toward 0)
//   DEF_DIVn    : default clocks-per-frame for speed settings 0..3
package anim_pkg;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } seq_state_e;

  localparam int DEF_DIV0 = 50000000;
  localparam int DEF_DIV1 = 25000000;
  localparam int DEF_DIV2 = 12500000;
  localparam int DEF_DIV3 = 6250000;

endpackage

// File: rtl/anim_prescaler.sv
// anim_prescaler -- frame-rate prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : 1 = count, 0 = hold the count
//   restart    : synchronous clear of the count
//   speed      : selects DIV0..DIV3 clocks per frame
//   adv        : high in the cycle whose rising edge advances the frame
module anim_prescaler
  import anim_pkg::*;
#(
  parameter int PW   = 26,
  parameter int DIV0 = DEF_DIV0,
  parameter int DIV1 = DEF_DIV1,
  parameter int DIV2 = DEF_DIV2,
  parameter int DIV3 = DEF_DIV3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       restart,
  input  logic [1:0] speed,
  output logic       adv
);

  logic [PW-1:0] cnt;
  logic [PW-1:0] div_m1;

  always_comb begin
    div_m1 = PW'(DIV0 - 1);
    case (speed)
      2'd0: div_m1 = PW'(DIV0 - 1);
      2'd1: div_m1 = PW'(DIV1 - 1);
      2'd2: div_m1 = PW'(DIV2 - 1);
      2'd3: div_m1 = PW'(DIV3 - 1);
      default: div_m1 = PW'(DIV0 - 1);
    endcase
  end

  // A ">=" compare rather than "==" means a speed change that lands below the
  // current count still advances on the next enabled edge instead of waiting
  // for the counter to wrap its full range.
  assign adv = run & (cnt >= div_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || adv) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/anim_frame_seq.sv
// anim_frame_seq -- animation frame sequencer with loop and bounce modes.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : 1 = advance frames, 0 = freeze
//   restart    : synchronous pulse, reloads the start frame (0 or LAST per dir)
//   dir        : 0 = up, 1 = down (loop mode and restart)
//   pingpong   : 0 = loop mode, 1 = bounce mode
//   speed      : prescaler select
//   frame      : current frame index, 0..LAST
//   tick       : one-cycle pulse in the first cycle a new frame is presented
//   wrap       : one-cycle pulse with tick when a full sequence completes
//   state      : bounce FSM state, exposed for observation
//
// Output handshake: tick acts as the valid strobe for frame; there is no
// ready. A consumer samples frame/wrap in any cycle where tick is high, and
// frame stays stable until the next tick, restart or reset.
module anim_frame_seq
  import anim_pkg::*;
#(
  parameter int         PW   = 26,
  parameter int         DIV0 = DEF_DIV0,
  parameter int         DIV1 = DEF_DIV1,
  parameter int         DIV2 = DEF_DIV2,
  parameter int         DIV3 = DEF_DIV3,
  parameter logic [4:0] LAST = 5'd31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       restart,
  input  logic       dir,
  input  logic       pingpong,
  input  logic [1:0] speed,
  output logic [4:0] frame,
  output logic       tick,
  output logic       wrap,
  output seq_state_e state
);

  logic       adv;
  logic       armed;      // bounce state is valid; until set, dir seeds it
  logic       armed_d;
  logic [4:0] frame_d;
  logic       tick_d;
  logic       wrap_d;
  seq_state_e state_d;
  seq_state_e eff_state;

  anim_prescaler #(
    .PW  (PW),
    .DIV0(DIV0),
    .DIV1(DIV1),
    .DIV2(DIV2),
    .DIV3(DIV3)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .restart(restart),
    .speed  (speed),
    .adv    (adv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= 5'd0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      state <= ST_UP;
      armed <= 1'b0;
    end else begin
      frame <= frame_d;
      tick  <= tick_d;
      wrap  <= wrap_d;
      state <= state_d;
      armed <= armed_d;
    end
  end

  always_comb begin
    frame_d   = frame;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    state_d   = state;
    armed_d   = armed;
    eff_state = armed ? state : (dir ? ST_DOWN : ST_UP);

    // Leaving bounce mode forgets the bounce direction so the next entry
    // takes it from dir again.
    if (!pingpong) begin
      armed_d = 1'b0;
    end

    if (restart) begin
      frame_d = dir ? LAST : 5'd0;
      state_d = dir ? ST_DOWN : ST_UP;
      armed_d = pingpong;
    end else if (adv) begin
      tick_d = 1'b1;
      if (!pingpong) begin
        if (!dir) begin
          if (frame >= LAST) begin
            frame_d = 5'd0;
            wrap_d  = 1'b1;
          end else begin
            frame_d = frame + 5'd1;
          end
        end else begin
          if (frame == 5'd0) begin
            frame_d = LAST;
            wrap_d  = 1'b1;
          end else if (frame > LAST) begin
            frame_d = LAST;
          end else begin
            frame_d = frame - 5'd1;
          end
        end
      end else begin
        armed_d = 1'b1;
        state_d = eff_state;
        case (eff_state)
          ST_UP: begin
            if (frame >= LAST) begin
              frame_d = LAST - 5'd1;
              state_d = ST_DOWN;
            end else begin
              frame_d = frame + 5'd1;
            end
          end
          ST_DOWN: begin
            if (frame == 5'd0) begin
              frame_d = 5'd1;
              state_d = ST_UP;
              wrap_d  = 1'b1;
            end else if (frame > LAST) begin
              frame_d = LAST;
            end else begin
              frame_d = frame - 5'd1;
            end
          end
          default: begin
            frame_d = 5'd0;
            state_d = ST_UP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anim_frame_seq.sv
// tb_anim_frame_seq -- directed bench for anim_frame_seq with DIV = 2/3/4/5.
// Each expected frame change is queued as {edge number, wrap, frame}; the
// monitor pops one entry per tick and compares all three fields.
module tb_anim_frame_seq;
  import anim_pkg::*;

  localparam int EW = 38;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       restart = 1'b0;
  logic       dir = 1'b0;
  logic       pingpong = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [4:0] frame;
  logic       tick;
  logic       wrap;
  seq_state_e state;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  anim_frame_seq #(
    .PW  (26),
    .DIV0(2),
    .DIV1(3),
    .DIV2(4),
    .DIV3(5),
    .LAST(5'd31)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .restart (restart),
    .dir     (dir),
    .pingpong(pingpong),
    .speed   (speed),
    .frame   (frame),
    .tick    (tick),
    .wrap    (wrap),
    .state   (state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int unsigned c, input logic w, input logic [4:0] f);
    exp_q.push_back({c, w, f});
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (tick) begin
      if (exp_q.size() == 0) begin
        chk("tick_unexpected_queue_entries", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("frame", 64'(frame), 64'(e[4:0]));
        chk("wrap", 64'(wrap), 64'(e[5]));
        chk("tick_cycle", 64'(cyc), 64'(e[EW-1:6]));
      end
    end else if (wrap) begin
      chk("wrap_without_tick", 64'(wrap), 64'd0);
    end
    if (frame > 5'd31) chk("frame_range", 64'(frame), 64'd31);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse restart for one edge with run=1; returns the edge number after it.
  task automatic do_restart(input logic d, input logic pp, input logic [1:0] spd,
                            input logic [4:0] exp_frame, output int unsigned base);
    restart  = 1'b1;
    dir      = d;
    pingpong = pp;
    speed    = spd;
    run      = 1'b1;
    step(1);
    restart = 1'b0;
    chk("restart_frame", 64'(frame), 64'(exp_frame));
    chk("restart_tick", 64'(tick), 64'd0);
    chk("restart_wrap", 64'(wrap), 64'd0);
    base = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned base;
    int unsigned r;

    // Reset values while rst_n is held low.
    step(3);
    chk("reset_frame", 64'(frame), 64'd0);
    chk("reset_tick", 64'(tick), 64'd0);
    chk("reset_wrap", 64'(wrap), 64'd0);
    chk("reset_state", 64'(state), 64'(ST_UP));

    // Loop up, DIV=2: frames 1..31 then 0 with wrap, two edges apart.
    rst_n = 1'b1;
    run   = 1'b1;
    base  = cyc;
    for (int k = 1; k <= 32; k++) push_exp(base + 2 * k, k == 32, 5'(k % 32));
    step(64);
    run = 1'b0;

    // Loop down from restart: 31 then 30..0, then 31 with wrap.
    do_restart(1'b1, 1'b0, 2'd0, 5'd31, base);
    for (int k = 1; k <= 31; k++) push_exp(base + 2 * k, 1'b0, 5'(31 - k));
    push_exp(base + 64, 1'b1, 5'd31);
    step(64);
    run = 1'b0;

    // Bounce, DIV=3, up first; dir flipped afterwards must be ignored.
    do_restart(1'b0, 1'b1, 2'd1, 5'd0, base);
    chk("bounce_state_up", 64'(state), 64'(ST_UP));
    dir = 1'b1;
    for (int k = 1; k <= 31; k++) push_exp(base + 3 * k, 1'b0, 5'(k));
    for (int k = 32; k <= 62; k++) push_exp(base + 3 * k, 1'b0, 5'(62 - k));
    push_exp(base + 3 * 63, 1'b1, 5'd1);
    step(96);
    chk("bounce_peak_frame", 64'(frame), 64'd30);
    chk("bounce_peak_state", 64'(state), 64'(ST_DOWN));
    step(93);
    chk("bounce_end_state", 64'(state), 64'(ST_UP));
    run = 1'b0;
    dir = 1'b0;

    // Freeze at frame 5 with cnt=2 (DIV=5), then resume.
    do_restart(1'b0, 1'b0, 2'd3, 5'd0, base);
    for (int k = 1; k <= 5; k++) push_exp(base + 5 * k, 1'b0, 5'(k));
    step(27);                         // frame 5 at base+25, cnt now 2
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("hold_frame", 64'(frame), 64'd5);
      chk("hold_tick", 64'(tick), 64'd0);
    end
    run = 1'b1;
    push_exp(base + 37, 1'b0, 5'd6); // cnt 2->3->4, advance on the third edge
    step(3);
    // Speed change mid-count: cnt=3 at DIV=5, switch to DIV=2 -> next edge.
    step(3);
    speed = 2'd0;
    push_exp(base + 41, 1'b0, 5'd7);
    push_exp(base + 43, 1'b0, 5'd8);
    step(3);
    run = 1'b0;

    // Restart and advance on the same edge at frame 10.
    do_restart(1'b0, 1'b0, 2'd0, 5'd0, base);
    for (int k = 1; k <= 10; k++) push_exp(base + 2 * k, 1'b0, 5'(k));
    step(21);
    restart = 1'b1;
    dir     = 1'b1;
    step(1);
    restart = 1'b0;
    chk("collide_frame", 64'(frame), 64'd31);
    chk("collide_tick", 64'(tick), 64'd0);
    push_exp(base + 24, 1'b0, 5'd30); // cnt was cleared: full DIV before next
    step(2);

    // Asynchronous reset mid-frame at frame 17.
    do_restart(1'b0, 1'b0, 2'd0, 5'd0, base);
    for (int k = 1; k <= 17; k++) push_exp(base + 2 * k, 1'b0, 5'(k));
    step(35);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_frame", 64'(frame), 64'd0);
    chk("async_rst_tick", 64'(tick), 64'd0);
    chk("async_rst_wrap", 64'(wrap), 64'd0);
    chk("async_rst_state", 64'(state), 64'(ST_UP));
    step(2);
    rst_n = 1'b1;
    r = cyc;
    for (int k = 1; k <= 3; k++) push_exp(r + 2 * k, 1'b0, 5'(k));
    step(6);
    run = 1'b0;
    step(4);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
